// File: rtl/flash_sample_reader.sv
// rtl/flash_sample_reader.sv - SPI flash reader fetching one 16-bit little-endian PCM sample per request
//
// Purpose:
//   Each accepted fetch_pulse runs one SPI mode-0 read (opcode, 24-bit address,
//   optional dummy byte, two data bytes) and presents the result on sample with
//   a one-cycle sample_valid. Maintains a wrapping sample address pointer that
//   steps by +/-2 bytes inside [REGION_START, REGION_END).
//
// Optional feature macro: FLASH_FAST_READ_EN
//   defined   -> opcode 0x0B with an 8-bit dummy phase (MOSI held 0)
//   undefined -> opcode 0x03, no dummy phase
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   fetch_pulse       single-cycle request for the next sample
//   reverse           1 = step the pointer downward (latched per request)
//   restart           reload the pointer; aborts any transfer in progress
//   spi_cs_n          flash chip select, active low
//   spi_sclk          SPI clock, mode 0, one bit per two clk cycles
//   spi_mosi          command/address out
//   spi_miso          data in
//   sample            last sample read, held between reads
//   sample_valid      one-cycle strobe when sample updates
//   busy              high from request accept through CS_HOLD
//   overrun           one-cycle strobe when a fetch_pulse was dropped while busy

module flash_sample_reader #(
  parameter int                    ADDR_WIDTH   = 24,
  parameter logic [ADDR_WIDTH-1:0] REGION_START = '0,
  parameter logic [ADDR_WIDTH:0]   REGION_END   = (ADDR_WIDTH+1)'(24'h100000)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_pulse,
  input  logic        reverse,
  input  logic        restart,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  localparam int         TX_W   = 40;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  localparam int         TX_W   = 32;
`endif

  // Last even byte address of the region; target of reverse wrap and reverse restart.
  localparam logic [ADDR_WIDTH-1:0] REGION_LAST =
    ADDR_WIDTH'(REGION_END - (ADDR_WIDTH+1)'(2));

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD,
    S_ADDR,
`ifdef FLASH_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA,
    S_CS_HOLD
  } state_t;

  state_t                  state;
  state_t                  seg_next;
  logic [4:0]              seg_last;
  logic [4:0]              bit_cnt;
  logic                    phase;     // 0 = SCLK low half, 1 = SCLK high half
  logic                    dir;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   ptr_next;
  logic [ADDR_WIDTH-1:0]   ptr_reload;
  logic [ADDR_WIDTH:0]     ptr_fwd;
  logic [23:0]             addr24;
  logic [TX_W-1:0]         tx_load;
  logic [TX_W-1:0]         tx_sr;
  logic [14:0]             rx_sr;
  logic [15:0]             rx_next;

  // Pointer is zero-extended (or truncated) onto the 24-bit flash address field.
  assign addr24 = 24'(ptr);

`ifdef FLASH_FAST_READ_EN
  assign tx_load = {OPCODE, addr24, 8'h00};
`else
  assign tx_load = {OPCODE, addr24};
`endif

  assign rx_next    = {rx_sr, spi_miso};
  assign ptr_fwd    = {1'b0, ptr} + (ADDR_WIDTH+1)'(2);
  assign ptr_reload = reverse ? REGION_LAST : REGION_START;

  // Forward compare is done one bit wider so a region ending at the top of the
  // address space still wraps correctly.
  always_comb begin
    ptr_next = ptr;
    if (!dir) begin
      if (ptr_fwd >= REGION_END) ptr_next = REGION_START;
      else                       ptr_next = ptr_fwd[ADDR_WIDTH-1:0];
    end else begin
      if (ptr == REGION_START) ptr_next = REGION_LAST;
      else                     ptr_next = ptr - ADDR_WIDTH'(2);
    end
  end

  // Length and successor of each shifting segment.
  always_comb begin
    seg_last = 5'd0;
    seg_next = S_IDLE;
    case (state)
      S_CMD: begin
        seg_last = 5'd7;
        seg_next = S_ADDR;
      end
      S_ADDR: begin
        seg_last = 5'd23;
`ifdef FLASH_FAST_READ_EN
        seg_next = S_DUMMY;
`else
        seg_next = S_DATA;
`endif
      end
`ifdef FLASH_FAST_READ_EN
      S_DUMMY: begin
        seg_last = 5'd7;
        seg_next = S_DATA;
      end
`endif
      S_DATA: begin
        seg_last = 5'd15;
        seg_next = S_CS_HOLD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      phase        <= 1'b0;
      dir          <= 1'b0;
      ptr          <= REGION_START;
      tx_sr        <= '0;
      rx_sr        <= '0;
      spi_cs_n     <= 1'b1;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      if (restart) begin
        // Restart beats everything, including a simultaneous fetch (no overrun).
        state    <= S_IDLE;
        bit_cnt  <= '0;
        phase    <= 1'b0;
        ptr      <= ptr_reload;
        spi_cs_n <= 1'b1;
        spi_sclk <= 1'b0;
        spi_mosi <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (fetch_pulse && state != S_IDLE) overrun <= 1'b1;
        case (state)
          S_IDLE: begin
            if (fetch_pulse) begin
              dir      <= reverse;
              tx_sr    <= tx_load;
              spi_mosi <= OPCODE[7];
              spi_cs_n <= 1'b0;
              busy     <= 1'b1;
              state    <= S_CS_SETUP;
            end
          end
          S_CS_SETUP: begin
            state   <= S_CMD;
            phase   <= 1'b0;
            bit_cnt <= '0;
          end
          S_CS_HOLD: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            if (!phase) begin
              spi_sclk <= 1'b1;
              phase    <= 1'b1;
            end else begin
              // End of the high half: sample MISO, drop SCLK, present next MOSI bit.
              spi_sclk <= 1'b0;
              phase    <= 1'b0;
              tx_sr    <= tx_sr << 1;
              spi_mosi <= tx_sr[TX_W-2];
              if (state == S_DATA) rx_sr <= rx_next[14:0];
              if (bit_cnt == seg_last) begin
                bit_cnt <= '0;
                state   <= seg_next;
                if (state == S_DATA) begin
                  // First byte on the wire is the low byte of the sample.
                  spi_cs_n     <= 1'b1;
                  spi_mosi     <= 1'b0;
                  sample       <= {rx_next[7:0], rx_next[15:8]};
                  sample_valid <= 1'b1;
                  ptr          <= ptr_next;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_sample_reader.sv
// tb/tb_flash_sample_reader.sv - directed self-checking bench for flash_sample_reader
module tb_flash_sample_reader;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int         HDR = 40;
  localparam int         LAT = 114;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int         HDR = 32;
  localparam int         LAT = 98;
`endif
  localparam int KMAX = LAT + 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        fetch [2];
  logic        rev [2];
  logic        restart [2];
  logic        cs_n [2];
  logic        sclk [2];
  logic        mosi [2];
  logic        miso [2];
  logic [15:0] sample [2];
  logic        valid [2];
  logic        busy [2];
  logic        ovr [2];

  flash_sample_reader dut0 (
    .clk(clk), .rst(rst), .fetch_pulse(fetch[0]), .reverse(rev[0]), .restart(restart[0]),
    .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]),
    .sample(sample[0]), .sample_valid(valid[0]), .busy(busy[0]), .overrun(ovr[0])
  );

  flash_sample_reader #(
    .ADDR_WIDTH(24), .REGION_START(24'h000100), .REGION_END(25'h0000104)
  ) dut1 (
    .clk(clk), .rst(rst), .fetch_pulse(fetch[1]), .reverse(rev[1]), .restart(restart[1]),
    .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]),
    .sample(sample[1]), .sample_valid(valid[1]), .busy(busy[1]), .overrun(ovr[1])
  );

  // Flash models: capture command/address on SCLK rise, drive data bits in the low half.
  logic [15:0] word [2];      // bytes in wire order: {first byte, second byte}
  logic [7:0]  cap_cmd [2];
  logic [23:0] cap_addr [2];
  logic        dummy_hi [2];
  int          rises [2];
  int          bitc [2];
  logic        ps [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_n[g] !== 1'b0) begin
        bitc[g] = 0;
        miso[g] = 1'b0;
      end else if (sclk[g] === 1'b1 && ps[g] === 1'b0) begin
        if (bitc[g] == 0) begin
          cap_cmd[g] = '0; cap_addr[g] = '0; dummy_hi[g] = 1'b0; rises[g] = 0;
        end
        if (bitc[g] < 8)        cap_cmd[g]  = {cap_cmd[g][6:0], mosi[g]};
        else if (bitc[g] < 32)  cap_addr[g] = {cap_addr[g][22:0], mosi[g]};
        else if (bitc[g] < HDR) dummy_hi[g] = dummy_hi[g] | mosi[g];
        bitc[g]++;
        rises[g]++;
      end else if (sclk[g] === 1'b0 && ps[g] === 1'b1 && bitc[g] >= HDR && bitc[g] < HDR + 16) begin
        miso[g] = word[g][15 - (bitc[g] - HDR)];
      end
      ps[g] = sclk[g];
    end
  end

  int errors = 0;
  int checks = 0;

  logic        busy_s [KMAX+1];
  logic        cs_s   [KMAX+1];
  logic        sclk_s [KMAX+1];
  logic        ovr_s  [KMAX+1];
  int          vcnt, vk;
  logic [15:0] vsample;
  int          dn_valid;
  logic        dn_done;
  logic [15:0] dn_sample;

  // Fetch in cycle N; optional extra fetch / restart in cycle N+fk / N+rk; record N+1..N+KMAX.
  task automatic xfer(input int g, input int fk, input int rk);
    vcnt = 0; vk = -1; vsample = '0;
    @(posedge clk); #1 fetch[g] = 1'b1;
    for (int k = 1; k <= KMAX; k++) begin
      @(posedge clk); #1 fetch[g] = (k == fk); restart[g] = (k == rk);
      @(negedge clk);
      busy_s[k] = busy[g]; cs_s[k] = cs_n[g]; sclk_s[k] = sclk[g]; ovr_s[k] = ovr[g];
      if (valid[g]) begin
        vcnt++;
        if (vk < 0) begin vk = k; vsample = sample[g]; end
      end
    end
    @(posedge clk); #1 fetch[g] = 1'b0; restart[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    dn_valid = 0; dn_done = 1'b0; dn_sample = '0;
    for (int i = 0; i < 300 && !dn_done; i++) begin
      @(negedge clk);
      if (valid[g]) begin dn_valid++; dn_sample = sample[g]; end
      if (!busy[g]) dn_done = 1'b1;
    end
  endtask

  task automatic pulse_restart(input int g);
    @(posedge clk); #1 restart[g] = 1'b1;
    @(posedge clk); #1 restart[g] = 1'b0;
  endtask

  task automatic check_addr(input string name, input int g, input logic [23:0] exp);
    xfer(g, 0, 0);
    checks++;
    if (cap_addr[g] !== exp) begin
      errors++; $display("FAIL %s: addr got %h want %h", name, cap_addr[g], exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      fetch[g] = 1'b0; rev[g] = 1'b0; restart[g] = 1'b0; word[g] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({cs_n[g], sclk[g], mosi[g], valid[g], busy[g], ovr[g]} !== 6'b100000) begin
        errors++;
        $display("FAIL reset_pins[%0d]: got %b want 100000", g,
                 {cs_n[g], sclk[g], mosi[g], valid[g], busy[g], ovr[g]});
      end
      checks++;
      if (sample[g] !== 16'h0000) begin
        errors++; $display("FAIL reset_sample[%0d]: got %h want 0000", g, sample[g]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_forward;
    word[0] = 16'h3412;
    xfer(0, 0, 0);
    checks++;
    if ({busy_s[1], cs_s[1]} !== 2'b10) begin
      errors++; $display("FAIL accept: busy,cs_n got %b want 10", {busy_s[1], cs_s[1]});
    end
    checks++;
    if ({sclk_s[2], sclk_s[3]} !== 2'b01) begin
      errors++; $display("FAIL first_rise: sclk N+2,N+3 got %b want 01", {sclk_s[2], sclk_s[3]});
    end
    checks++;
    if (cap_cmd[0] !== OPC) begin
      errors++; $display("FAIL opcode: got %h want %h", cap_cmd[0], OPC);
    end
    checks++;
    if (cap_addr[0] !== 24'h000000) begin
      errors++; $display("FAIL fwd_addr0: got %h want 000000", cap_addr[0]);
    end
    checks++;
    if (rises[0] != HDR + 16 || dummy_hi[0] !== 1'b0) begin
      errors++; $display("FAIL sclk_count: got %0d dummy_hi %b want %0d dummy_hi 0", rises[0], dummy_hi[0], HDR + 16);
    end
    checks++;
    if (vk != LAT || vcnt != 1) begin
      errors++; $display("FAIL valid_latency: got N+%0d count %0d want N+%0d count 1", vk, vcnt, LAT);
    end
    checks++;
    if (vsample !== 16'h1234) begin
      errors++; $display("FAIL fwd_sample: got %h want 1234", vsample);
    end
    checks++;
    if ({busy_s[LAT], busy_s[LAT+1], cs_s[LAT]} !== 3'b101) begin
      errors++; $display("FAIL busy_fall: got %b want 101", {busy_s[LAT], busy_s[LAT+1], cs_s[LAT]});
    end
    word[0] = 16'hEFBE;
    check_addr("fwd_addr1", 0, 24'h000002);
    checks++;
    if (vsample !== 16'hBEEF) begin
      errors++; $display("FAIL fwd_sample2: got %h want beef", vsample);
    end
  endtask

  task automatic test_back_to_back;
    word[0] = 16'h5566;
    xfer(0, LAT + 1, 0);
    checks++;
    if ({busy_s[LAT+2], ovr_s[LAT+2]} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept: busy,overrun got %b want 10", {busy_s[LAT+2], ovr_s[LAT+2]});
    end
    drain(0);
    checks++;
    if (!dn_done || dn_valid != 1 || dn_sample !== 16'h6655) begin
      errors++; $display("FAIL b2b_second: done %b valids %0d sample %h want 1 1 6655", dn_done, dn_valid, dn_sample);
    end
    checks++;
    if (cap_addr[0] !== 24'h000006) begin
      errors++; $display("FAIL b2b_addr: got %h want 000006", cap_addr[0]);
    end
  endtask

  task automatic test_overrun;
    word[0] = 16'h0102;
    xfer(0, 40, 0);
    checks++;
    if ({ovr_s[40], ovr_s[41], ovr_s[42]} !== 3'b010) begin
      errors++; $display("FAIL overrun_strobe: got %b want 010", {ovr_s[40], ovr_s[41], ovr_s[42]});
    end
    checks++;
    if (vcnt != 1 || busy_s[LAT+2] !== 1'b0) begin
      errors++; $display("FAIL overrun_single: valids %0d busy %b want 1 0", vcnt, busy_s[LAT+2]);
    end
    check_addr("overrun_ptr", 0, 24'h00000A);
  endtask

  task automatic test_abort;
    word[0] = 16'hAAAA;
    xfer(0, 0, 50);
    checks++;
    if ({cs_s[51], busy_s[51]} !== 2'b10) begin
      errors++; $display("FAIL abort_idle: cs_n,busy got %b want 10", {cs_s[51], busy_s[51]});
    end
    checks++;
    if (vcnt != 0 || sample[0] !== 16'h0201) begin
      errors++; $display("FAIL abort_sample: valids %0d sample %h want 0 0201", vcnt, sample[0]);
    end
    word[0] = 16'h7788;
    check_addr("abort_ptr", 0, 24'h000000);
    checks++;
    if (vsample !== 16'h8877) begin
      errors++; $display("FAIL abort_next_sample: got %h want 8877", vsample);
    end
  endtask

  task automatic test_restart_reverse;
    @(posedge clk); #1 rev[0] = 1'b1; restart[0] = 1'b1; fetch[0] = 1'b1;
    @(posedge clk); #1 restart[0] = 1'b0; fetch[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy[0], ovr[0]} !== 2'b00) begin
      errors++; $display("FAIL restart_wins: busy,overrun got %b want 00", {busy[0], ovr[0]});
    end
    check_addr("rev_restart_addr", 0, 24'h0FFFFE);
    check_addr("rev_step_addr", 0, 24'h0FFFFC);
    rev[0] = 1'b0;
  endtask

  task automatic test_fwd_wrap;
    word[1] = 16'hCDAB;
    check_addr("fwrap0", 1, 24'h000100);
    check_addr("fwrap1", 1, 24'h000102);
    check_addr("fwrap2", 1, 24'h000100);
    checks++;
    if (vsample !== 16'hABCD) begin
      errors++; $display("FAIL fwrap_sample: got %h want abcd", vsample);
    end
  endtask

  task automatic test_rev_wrap;
    rev[1] = 1'b1;
    pulse_restart(1);
    check_addr("rwrap0", 1, 24'h000102);
    check_addr("rwrap1", 1, 24'h000100);
    check_addr("rwrap2", 1, 24'h000102);
    rev[1] = 1'b0;
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1 fetch[0] = 1'b1;
    @(posedge clk); #1 fetch[0] = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cs_n[0], sclk[0], mosi[0], valid[0], busy[0], ovr[0]} !== 6'b100000 || sample[0] !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: pins %b sample %h want 100000 0000",
               {cs_n[0], sclk[0], mosi[0], valid[0], busy[0], ovr[0]}, sample[0]);
    end
    @(posedge clk); #1 rst = 1'b0;
    check_addr("post_reset_addr", 0, 24'h000000);
  endtask

  initial begin
    test_reset;
    test_forward;
    test_back_to_back;
    test_overrun;
    test_abort;
    test_restart_reverse;
    test_fwd_wrap;
    test_rev_wrap;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
